// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. rx is synchronised and each bit is decided by a
//   3-point majority vote around its mid-point. Glitches on the start bit are
//   rejected. Received words, with per-word frame/parity error flags, are
//   delivered through a ready/valid output buffer. Breaks and overruns are
//   also reported.
//
//   Build option: define UART_RX_FIFO_EN to use a FIFO_DEPTH-entry FIFO as
//   the output buffer. Without it the buffer is a single holding register.
//
//   Ports:
//     clk, reset_n           clock, asynchronous active-low reset
//     rx                     serial input (asynchronous, idle high)
//     data_out/data_valid    head word of the output buffer / buffer non-empty
//     data_ready             consumer pops the head on data_valid & data_ready
//     frame_err, parity_err  error flags belonging to the head word
//     overrun                sticky; a word was dropped, cleared by the next pop
//     break_det              one-cycle pulse on a detected break
//     busy                   receiver FSM not idle
module uart_rx_param #(
    parameter int CLK_PER_BIT = 10416,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int M  = CLK_PER_BIT / 2;
    localparam int IW = 4;
    localparam int EW = DATA_BITS + 2;

    // Empty block: a legal depth (power of two, at least 2) never elaborates it.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   par_q, par_d;
    logic                   pe_q, pe_d;
    logic                   fe_q, fe_d;
    logic                   brk_q, brk_d;
    logic                   busy_q, busy_d;

    logic                   rx_s, mid, maj, fe_now, exp_par;
    logic                   push;
    logic [EW-1:0]          push_word;

    assign rx_s = sync2_q;
    // Decision cycle: the third of the three samples at M-1, M, M+1.
    assign mid  = (cnt_q == CW'(M + 1));
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign fe_now  = fe_q | ~maj;
    assign exp_par = (PARITY == 2) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d   = state_q;
        sync1_d   = rx;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_d     = par_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        brk_d     = 1'b0;
        push      = 1'b0;
        push_word = {shift_q, fe_now, pe_q};

        // The bit counter free-runs across states once a frame has started,
        // so every state's decision lands exactly one bit period after the last.
        if (state_q != S_IDLE) begin
            cnt_d = (cnt_q == CW'(CLK_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(M - 1)) smp_d[0] = rx_s;
            if (cnt_q == CW'(M))     smp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (mid) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        fe_d    = 1'b0;
                        pe_d    = 1'b0;
                        par_d   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PAR: begin
                if (mid) begin
                    par_d   = maj;
                    pe_d    = maj ^ exp_par;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    if (idx_q == '0 && shift_q == '0 && (PARITY == 0 || !par_q) && !maj) begin
                        brk_d   = 1'b1;
                        state_d = S_BRK;
                    end else if (idx_q == IW'(STOP_BITS - 1)) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d  = fe_now;
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_BRK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            smp_q   <= 2'b11;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
            busy_q  <= busy_d;
        end
    end

    assign break_det = brk_q;
    assign busy      = busy_q;

    logic ovr_q, ovr_d;
    logic pop;
    assign overrun = ovr_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic          full, wr_en;

    assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = (fcnt_q != '0) & data_ready;
    // A same-cycle pop frees the slot the push needs.
    assign wr_en = push & (!full | pop);

    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        fcnt_d = fcnt_q;
        ovr_d  = ovr_q;
        if (pop) begin
            rd_d  = rd_q + AW'(1);
            ovr_d = 1'b0;
        end
        if (wr_en) begin
            mem_d[wr_q] = push_word;
            wr_d        = wr_q + AW'(1);
        end else if (push) begin
            ovr_d = 1'b1;
        end
        fcnt_d = fcnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fcnt_q <= fcnt_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_valid = (fcnt_q != '0);
    assign data_out   = mem_q[rd_q][EW-1:2];
    assign frame_err  = mem_q[rd_q][1];
    assign parity_err = mem_q[rd_q][0];
`else
    logic [EW-1:0] hold_q, hold_d;
    logic          full_q, full_d;

    assign pop = full_q & data_ready;

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        ovr_d  = ovr_q;
        if (pop) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (push) begin
            if (full_q && !pop) begin
                ovr_d = 1'b1;
            end else begin
                hold_d = push_word;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_valid = full_q;
    assign data_out   = hold_q[EW-1:2];
    assign frame_err  = hold_q[1];
    assign parity_err = hold_q[0];
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two receivers on one clock, A = 8N1, B = 8E2,
// both at 16 clocks per bit. Frames are built bit by bit on each rx pin and the
// results compared against hand-written tables and a frame-level model.
module tb_uart_rx_param;

    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] rx = 2'b11;
    logic [1:0] rdy = 2'b00;
    logic [1:0] vld, fe, pe, ov, brk, busy;
    logic [7:0] dout_a, dout_b;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .rx(rx[0]),
        .data_out(dout_a), .data_valid(vld[0]), .data_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]),
        .break_det(brk[0]), .busy(busy[0]));

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .rx(rx[1]),
        .data_out(dout_b), .data_valid(vld[1]), .data_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]),
        .break_det(brk[1]), .busy(busy[1]));

    typedef struct packed { logic [7:0] d; logic fe; logic pe; } ent_t;
    typedef struct {
        int sel; logic [7:0] d; logic par; logic st0; logic st1;
        logic exp_vld; logic [7:0] exp_d; logic exp_fe; logic exp_pe; int exp_brk;
    } vec_t;

    ent_t mq0[$];
    ent_t mq1[$];
    bit   ov_m [2];
    int   brk_exp [2];
    int   brk_cnt [2];
    int   checks = 0;
    int   failures = 0;
    vec_t tbl [10];

    initial begin
        brk_cnt[0] = 0;
        brk_cnt[1] = 0;
    end

    // Pulses are counted once per cycle, so a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (brk[0]) brk_cnt[0] = brk_cnt[0] + 1;
        if (brk[1]) brk_cnt[1] = brk_cnt[1] + 1;
    end

    function automatic logic [7:0] dout(int s);
        return (s == 0) ? dout_a : dout_b;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bitt(int s, logic b);
        rx[s] = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(int s, logic [7:0] d, logic par, logic st0, logic st1, int idle);
        bitt(s, 1'b0);
        for (int i = 0; i < 8; i++) bitt(s, d[i]);
        if (s == 1) bitt(s, par);
        bitt(s, st0);
        if (s == 1) bitt(s, st1);
        for (int i = 0; i < idle; i++) bitt(s, 1'b1);
    endtask

    // Frame-level outcome: break, or a word with its flags into a bounded queue.
    task automatic model(int s, logic [7:0] d, logic par, logic st0, logic st1);
        ent_t e;
        int   qs;
        if (d == 8'h00 && (s == 0 || par == 1'b0) && st0 == 1'b0) begin
            brk_exp[s]++;
        end else begin
            e.d  = d;
            e.fe = !st0 || (s == 1 && !st1);
            e.pe = (s == 1) ? (($countones(d) % 2 == 1) != par) : 1'b0;
            qs = (s == 0) ? mq0.size() : mq1.size();
            if (qs >= DEPTH) ov_m[s] = 1'b1;
            else if (s == 0) mq0.push_back(e);
            else mq1.push_back(e);
        end
    endtask

    task automatic do_pop(int s);
        rdy[s] = 1'b1;
        @(negedge clk);
        rdy[s] = 1'b0;
    endtask

    task automatic pop_chk(int s, string name);
        ent_t e;
        e = (s == 0) ? mq0.pop_front() : mq1.pop_front();
        chk({name, "_vld"}, vld[s], 1);
        chk({name, "_data"}, dout(s), e.d);
        chk({name, "_fe"}, fe[s], e.fe);
        chk({name, "_pe"}, pe[s], e.pe);
        do_pop(s);
        ov_m[s] = 1'b0;
    endtask

    task automatic drain(int s, string name);
        while ((s == 0 ? mq0.size() : mq1.size()) > 0) pop_chk(s, name);
        chk({name, "_empty"}, vld[s], 0);
        chk({name, "_ovr"}, ov[s], ov_m[s]);
    endtask

    initial begin
        int   s;
        logic [7:0] d;
        logic par, st0, st1;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
        tbl[1] = '{0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0};
        tbl[2] = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 0};
        tbl[3] = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 0};
        tbl[4] = '{1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 0};
        tbl[5] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 0};
        tbl[6] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 0};
        tbl[7] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        tbl[8] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0};
        tbl[9] = '{1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_a", {dout_a, vld[0], fe[0], pe[0], ov[0], brk[0], busy[0]}, 0);
        chk("rst_b", {dout_b, vld[1], fe[1], pe[1], ov[1], brk[1], busy[1]}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed frames.
        for (int i = 0; i < 10; i++) begin
            s = tbl[i].sel;
            send(s, tbl[i].d, tbl[i].par, tbl[i].st0, tbl[i].st1, 2);
            brk_exp[s] += tbl[i].exp_brk;
            chk($sformatf("vec%0d_vld", i), vld[s], tbl[i].exp_vld);
            chk($sformatf("vec%0d_brk", i), brk_cnt[s], brk_exp[s]);
            if (tbl[i].exp_vld) begin
                chk($sformatf("vec%0d_data", i), dout(s), tbl[i].exp_d);
                chk($sformatf("vec%0d_fe", i), fe[s], tbl[i].exp_fe);
                chk($sformatf("vec%0d_pe", i), pe[s], tbl[i].exp_pe);
            end
            if (i == 0) begin
                repeat (20) @(negedge clk);
                chk("hold_vld", vld[0], 1);
                chk("hold_data", dout_a, 8'hA5);
            end
            if (vld[s]) do_pop(s);
            chk($sformatf("vec%0d_popped", i), vld[s], 0);
        end

        // Start-bit glitch: 6 clocks low.
        rx[0] = 1'b0;
        repeat (6) @(negedge clk);
        rx[0] = 1'b1;
        chk("glitch_busy_hi", busy[0], 1);
        repeat (30) @(negedge clk);
        chk("glitch_busy_lo", busy[0], 0);
        chk("glitch_vld", vld[0], 0);
        chk("glitch_brk", brk_cnt[0], brk_exp[0]);

        // Break: 12 bit times low, then idle, then a normal frame.
        repeat (12) bitt(0, 1'b0);
        brk_exp[0]++;
        chk("brk_pulse", brk_cnt[0], brk_exp[0]);
        chk("brk_vld", vld[0], 0);
        chk("brk_wait_busy", busy[0], 1);
        repeat (2) bitt(0, 1'b1);
        chk("brk_idle", busy[0], 0);
        send(0, 8'hC3, 1'b0, 1'b1, 1'b1, 2);
        model(0, 8'hC3, 1'b0, 1'b1, 1'b1);
        drain(0, "after_brk");

        // Overrun: one more word than the buffer holds, no consumer.
        for (int i = 0; i <= DEPTH; i++) begin
            d = 8'($urandom);
            send(0, d, 1'b0, 1'b1, 1'b1, 1);
            model(0, d, 1'b0, 1'b1, 1'b1);
        end
        chk("ovr_set", ov[0], 1);
        pop_chk(0, "ovr_pop");
        chk("ovr_clr", ov[0], 0);
        drain(0, "ovr_drain");

        // Randomised frames against the model.
        for (int i = 0; i < 24; i++) begin
            s   = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            par = 1'($urandom);
            st0 = ($urandom_range(0, 4) != 0);
            st1 = ($urandom_range(0, 4) != 0);
            send(s, d, par, st0, st1, 2);
            model(s, d, par, st0, st1);
            chk($sformatf("rnd%0d_brk", i), brk_cnt[s], brk_exp[s]);
            chk($sformatf("rnd%0d_ovr", i), ov[s], ov_m[s]);
            chk($sformatf("rnd%0d_vld", i), vld[s], ((s == 0 ? mq0.size() : mq1.size()) > 0));
            if ($urandom_range(0, 2) != 0) drain(s, $sformatf("rnd%0d", i));
        end
        drain(0, "rnd_end_a");
        drain(1, "rnd_end_b");

        // Reset mid-frame with a word pending on B.
        send(1, 8'h42, 1'b0, 1'b1, 1'b1, 1);
        model(1, 8'h42, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_b_vld", vld[1], 1);
        bitt(0, 1'b0);
        for (int i = 0; i < 4; i++) bitt(0, 1'b1);
        reset_n = 1'b0;
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_a", {dout_a, vld[0], fe[0], pe[0], ov[0], brk[0], busy[0]}, 0);
        chk("midrst_b", {dout_b, vld[1], fe[1], pe[1], ov[1], brk[1], busy[1]}, 0);
        mq0.delete();
        mq1.delete();
        ov_m[0] = 1'b0;
        ov_m[1] = 1'b0;
        reset_n = 1'b1;
        repeat (2) bitt(0, 1'b1);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b1, 2);
        model(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        drain(0, "post_rst_a");
        chk("post_rst_b_vld", vld[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the FPGA temperature-control datapath. It replaces the fixed 8N1 receiver with configurable data width, parity and stop bits. Each bit is sampled with a 3-point majority vote, and glitches on the start bit are rejected. Received words go through a ready/valid output buffer, with per-word error flags and break/overrun reporting. It sits between the board RX pin and the command/sensor parser.

## Interface
- CLK_PER_BIT, 10416: clk cycles per bit; minimum 8.
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: output buffer depth, power of 2, ≥2. Used only with UART_RX_FIFO_EN.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, asynchronous, idle high.
- data_out  out  DATA_BITS  head word of the buffer, LSB received first.
- data_valid  out  1  buffer non-empty; data_out, frame_err and parity_err are valid.
- data_ready  in  1  consumer accepts the head word when data_valid & data_ready at a clk edge.
- frame_err  out  1  head word had a 0 in a stop bit.
- parity_err  out  1  head word failed the parity check; always 0 when PARITY = 0.
- overrun  out  1  sticky; a word was dropped because the buffer was full.
- break_det  out  1  single-cycle pulse when a break is detected.
- busy  out  1  FSM is not in IDLE.

## Operation
- rx passes through a 2-FF synchroniser; both flops reset to 1.
- Bit counter width is $clog2(CLK_PER_BIT).
- Mid-bit sample: majority of the synchronised rx at counts M-1, M, M+1, where M = CLK_PER_BIT/2.
- FSM states and transitions:
  - IDLE: a synchronised 0 → START, counter cleared.
  - START: majority at mid-bit. If 1, it is a false start → IDLE with no flags. If 0 → DATA.
  - DATA: DATA_BITS samples taken one CLK_PER_BIT apart, shifted in LSB first. Then → PARITY if PARITY ≠ 0, otherwise → STOP.
  - PARITY: parity_err = sampled bit XOR the expected bit. Even mode: data XOR parity bit must be 0. Odd mode: it must be 1.
  - STOP: sample each stop bit at its mid-point; a 0 in any stop bit sets frame_err.
    - Break: data all 0, parity bit 0 (if present) and first stop bit 0. Pulse break_det, push nothing, → BRK_WAIT.
    - Otherwise, at the mid-point of the last stop bit, push {word, frame_err, parity_err} → IDLE.
    - Returning to IDLE at mid-stop lets the receiver resync on back-to-back frames.
  - BRK_WAIT: wait for synchronised rx = 1 → IDLE.
- Buffer behaviour:
  - Push when full: the word is dropped, overrun is set and the buffer contents are unchanged.
  - Simultaneous push and pop when full: both take effect and no overrun occurs.
  - overrun clears on the next pop.
- Reset mid-frame: FSM → IDLE, buffer emptied, partial word discarded.

## Timing
- Reset values:
  - data_out = 0, data_valid = 0, frame_err = 0, parity_err = 0.
  - overrun = 0, break_det = 0, busy = 0.
  - Synchroniser = 1.
- Input latency: 2 clk from the rx pin to the FSM.
- First sample after the falling edge: M+1 clk after the synchronised edge.
- Output latency: data_valid rises 1 clk after the last-stop-bit mid-sample, which is about (1 + DATA_BITS + P + STOP_BITS − 0.5)·CLK_PER_BIT + 3 clk after the start edge. P = 1 if PARITY ≠ 0, else 0.
- Pop: on the handshake edge, data_out shows the next entry the same edge.
- Handshake rules:
  - data_out and the error flags are held stable while data_valid & !data_ready.
  - data_valid never deasserts without a pop, except on reset.
- busy rises 1 clk after the synchronised falling edge and falls on the transition to IDLE.

## Configuration
- UART_RX_FIFO_EN defined: FIFO of FIFO_DEPTH entries, each DATA_BITS+2 bits wide.
- Not defined: a single holding register of depth 1. A push when it is full, with no same-cycle pop, is an overrun.

## Test plan
- CLK_PER_BIT = 16, 8N1, send 0xA5 → one word 0xA5, frame_err = 0, parity_err = 0; data_valid held until data_ready.
- rx low for 6 clk then high → busy pulses, no word, no flags, FSM back in IDLE.
- PARITY = 1, send 0x03 with parity bit 1 → word 0x03 with parity_err = 1. Send it with parity bit 0 → parity_err = 0.
- Send 0x5A with stop bit 0 followed by idle → word 0x5A with frame_err = 1. rx held low for 12 bit times → break_det single pulse, no word, idle again after rx returns high.
- data_ready = 0, FIFO_DEPTH = 4, send 5 words → 4 buffered in order, overrun = 1. One pop → overrun = 0.
- Assert reset_n low mid-DATA, then release and send 0x3C → only 0x3C is received; all outputs were at reset values while reset was asserted.
